// File: rtl/prefetch_pkg.sv
// Shared types and default sizing for the stream prefetch buffer.
// The FSM state encoding lives here so the top and the bench agree on it.
package prefetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEMAND,
    S_READY,
    S_PREFETCH
  } state_e;

  localparam int DefAddrW = 28;
  localparam int DefDataW = 128;
  localparam int DefDepth = 4;
  localparam int DefCntW  = 16;

endpackage

// File: rtl/prefetch_ring.sv
// Ring of prefetched lines: DEPTH x DATA_W storage with read/write pointers and an occupancy count.
// Push, pop and flush never coincide in normal use; flush wins if they ever do.
module prefetch_ring
  import prefetch_pkg::*;
#(
  parameter int DATA_W = DefDataW,
  parameter int DEPTH  = DefDepth,
  localparam int PtrW  = $clog2(DEPTH),
  localparam int CntW  = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CntW-1:0]   count_o
);

  logic [DATA_W-1:0] ring_q [DEPTH];
  logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
  logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
  logic [CntW-1:0]   count_q, count_d;

  // Flush discards all entries by snapping the read pointer onto the write pointer.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = wrPtr_q;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PtrW'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PtrW'(1);
      if (push_i && !pop_i)      count_d = count_q + CntW'(1);
      else if (pop_i && !push_i) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) ring_q[wrPtr_q] <= push_data_i;
  end

  assign head_data_o = ring_q[rdPtr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Sequential-stream prefetcher between the L1 miss port and main memory.
// Head hits are served combinationally; the tail is refilled while the cache is quiet.
module stream_prefetch_buffer
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = DefAddrW,
  parameter int DATA_W = DefDataW,
  parameter int DEPTH  = DefDepth,
  parameter int CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_mem_read,
  input  logic [ADDR_W-1:0] cache_mem_addr,
  output logic [DATA_W-1:0] cache_mem_rdata,
  output logic              cache_mem_ready,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pf_en,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int CntRW = $clog2(DEPTH) + 1;

  state_e            state_q;
  logic              memRead_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] headAddr_q;
  logic              pfActive_q;
  logic [CNT_W-1:0]  hitCnt_q;
  logic [CNT_W-1:0]  missCnt_q;

  logic [DATA_W-1:0] headData;
  logic [CntRW-1:0]  ringCount;
  logic              hit, miss, issue, push;

  // A match on any entry other than the head counts as a miss and flushes the stream.
  assign hit   = (state_q == S_IDLE) && cache_mem_read && (ringCount != '0)
                 && (cache_mem_addr == headAddr_q);
  assign miss  = (state_q == S_IDLE) && cache_mem_read && !hit;
  assign issue = (state_q == S_IDLE) && !cache_mem_read && pf_en && pfActive_q
                 && (ringCount < CntRW'(DEPTH));
  assign push  = (state_q == S_PREFETCH) && mem_ready;

  prefetch_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (mem_rdata),
    .pop_i       (hit),
    .flush_i     (miss),
    .head_data_o (headData),
    .count_o     (ringCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      memRead_q  <= 1'b0;
      memAddr_q  <= '0;
      data_q     <= '0;
      headAddr_q <= '0;
      pfActive_q <= 1'b0;
      hitCnt_q   <= '0;
      missCnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            headAddr_q <= headAddr_q + ADDR_W'(1);
            if (hitCnt_q != '1) hitCnt_q <= hitCnt_q + CNT_W'(1);
          end else if (miss) begin
            headAddr_q <= cache_mem_addr + ADDR_W'(1);
            pfActive_q <= 1'b1;
            if (missCnt_q != '1) missCnt_q <= missCnt_q + CNT_W'(1);
            memAddr_q  <= cache_mem_addr;
            memRead_q  <= 1'b1;
            state_q    <= S_DEMAND;
          end else if (issue) begin
            memAddr_q <= headAddr_q + ADDR_W'(ringCount);
            memRead_q <= 1'b1;
            state_q   <= S_PREFETCH;
          end
        end
        S_DEMAND: begin
          if (mem_ready) begin
            data_q    <= mem_rdata;
            memRead_q <= 1'b0;
            state_q   <= S_READY;
          end
        end
        S_READY: state_q <= S_IDLE;
        S_PREFETCH: begin
          if (mem_ready) begin
            memRead_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cache_mem_ready = hit || (state_q == S_READY);
  assign cache_mem_rdata = hit ? headData : ((state_q == S_READY) ? data_q : '0);
  assign mem_read        = memRead_q;
  assign mem_addr        = memAddr_q;
  assign hit_cnt         = hitCnt_q;
  assign miss_cnt        = missCnt_q;

endmodule

// File: tb/tb_stream_prefetch_buffer.sv
// Directed bench for stream_prefetch_buffer with a fixed-latency memory responder.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_stream_prefetch_buffer;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MemLat = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cache_mem_read;
  logic [AW-1:0] cache_mem_addr;
  logic [DW-1:0] cache_mem_rdata;
  logic          cache_mem_ready;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          pf_en;
  logic [3:0]    hit_cnt;
  logic [3:0]    miss_cnt;

  int vectorsApplied = 0;
  int miscompares = 0;

  logic [AW-1:0] issued[$];
  logic          prevMemRead;
  int            latCnt;

  logic [DW-1:0] dataOut;
  int            latOut;
  logic          mrOut;
  int            sizeMark;

  stream_prefetch_buffer #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (4),
    .CNT_W  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cache_mem_read  (cache_mem_read),
    .cache_mem_addr  (cache_mem_addr),
    .cache_mem_rdata (cache_mem_rdata),
    .cache_mem_ready (cache_mem_ready),
    .mem_read        (mem_read),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .pf_en           (pf_en),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
  );

  always #5 clk = ~clk;

  // Every line carries a pattern derived from its own address, so stale or misrouted data shows up.
  function automatic logic [DW-1:0] lineData(input logic [AW-1:0] a);
    return {4'h1, a, 4'h2, ~a, 32'hC001D00D, 4'h3, a ^ 28'h5A5A5A5};
  endfunction

  // Memory answers MemLat cycles after it first sees a request, and forgets everything on reset.
  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      latCnt    <= 0;
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
      latCnt    <= 0;
    end else if (mem_read) begin
      if (latCnt == MemLat - 1) begin
        mem_ready <= 1'b1;
        mem_rdata <= lineData(mem_addr);
      end
      latCnt <= latCnt + 1;
    end
  end

  // Log the address of every memory read at its rising edge of mem_read.
  always @(posedge clk) begin
    if (rst) begin
      prevMemRead <= 1'b0;
    end else begin
      prevMemRead <= mem_read;
      if (mem_read && !prevMemRead) issued.push_back(mem_addr);
    end
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkIssued(input string tag, input int idx, input logic [AW-1:0] expAddr);
    if (idx < issued.size()) checkOutput(tag, DW'(issued[idx]), DW'(expAddr));
    else checkOutput(tag, {DW{1'bx}}, DW'(expAddr));
  endtask

  // Holds a request until ready is seen, lets the consuming edge pass, returns on a falling edge.
  task automatic applyStimulus(input logic [AW-1:0] a, output logic [DW-1:0] data,
                               output int lat, output logic sawMemReady);
    logic got;
    logic prevMr;
    got = 1'b0;
    prevMr = 1'b0;
    data = '0;
    lat = -1;
    sawMemReady = 1'b0;
    cache_mem_addr = a;
    cache_mem_read = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (cache_mem_ready) begin
        got = 1'b1;
        lat = i;
        data = cache_mem_rdata;
        sawMemReady = prevMr;
        break;
      end
      prevMr = mem_ready;
      @(negedge clk);
    end
    if (!got) checkOutput("ready_timeout", DW'(got), DW'(1));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cache_mem_read = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cache_mem_read = 1'b0;
    cache_mem_addr = '0;
    pf_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_read", DW'(mem_read), DW'(0));
    checkOutput("rst_mem_addr", DW'(mem_addr), DW'(0));
    checkOutput("rst_ready", DW'(cache_mem_ready), DW'(0));
    checkOutput("rst_rdata", cache_mem_rdata, '0);
    checkOutput("rst_hit_cnt", DW'(hit_cnt), DW'(0));
    checkOutput("rst_miss_cnt", DW'(miss_cnt), DW'(0));
    rst = 1'b0;
    idle(2);
    checkOutput("no_pf_before_miss", DW'(issued.size()), DW'(0));

    // Cold miss at 0x100: 1 issue cycle + 5 memory cycles + 1 ready cycle.
    applyStimulus(28'h0000100, dataOut, latOut, mrOut);
    checkOutput("cold_data", dataOut, lineData(28'h0000100));
    checkOutput("cold_lat", DW'(latOut), DW'(7));
    checkOutput("cold_after_memrdy", DW'(mrOut), DW'(1));
    checkOutput("cold_miss_cnt", DW'(miss_cnt), DW'(1));
    idle(40);
    checkOutput("fill_issue_count", DW'(issued.size()), DW'(5));
    checkIssued("demand_0x100", 0, 28'h0000100);
    for (int i = 1; i <= 4; i++) checkIssued("pf_fill", i, 28'h0000100 + AW'(i));
    checkOutput("full_no_read", DW'(mem_read), DW'(0));

    // Back-to-back head hits, then the tail refills with 0x105 and 0x106.
    applyStimulus(28'h0000101, dataOut, latOut, mrOut);
    checkOutput("hit101_data", dataOut, lineData(28'h0000101));
    checkOutput("hit101_lat", DW'(latOut), DW'(0));
    applyStimulus(28'h0000102, dataOut, latOut, mrOut);
    checkOutput("hit102_data", dataOut, lineData(28'h0000102));
    checkOutput("hit102_lat", DW'(latOut), DW'(0));
    checkOutput("hit_cnt_2", DW'(hit_cnt), DW'(2));
    idle(30);
    checkOutput("refill_count", DW'(issued.size()), DW'(7));
    checkIssued("refill_105", 5, 28'h0000105);
    checkIssued("refill_106", 6, 28'h0000106);

    // Head is 0x103; 0x104 sits in the ring but is not the head, so it misses and flushes.
    applyStimulus(28'h0000104, dataOut, latOut, mrOut);
    checkOutput("nonhead_data", dataOut, lineData(28'h0000104));
    checkOutput("nonhead_lat", DW'(latOut), DW'(7));
    checkOutput("nonhead_miss_cnt", DW'(miss_cnt), DW'(2));
    checkIssued("nonhead_demand", 7, 28'h0000104);
    // One quiet edge issues the prefetch of 0x105; the demand for 0x105 then waits for it.
    idle(1);
    applyStimulus(28'h0000105, dataOut, latOut, mrOut);
    checkOutput("wait_hit_data", dataOut, lineData(28'h0000105));
    checkOutput("wait_hit_lat", DW'(latOut), DW'(6));
    checkOutput("wait_hit_cnt", DW'(hit_cnt), DW'(3));
    checkOutput("wait_miss_cnt", DW'(miss_cnt), DW'(2));
    idle(40);
    checkIssued("flush_head_pf", 8, 28'h0000105);
    checkIssued("no_extra_read", 9, 28'h0000106);
    checkIssued("refill_109", 12, 28'h0000109);
    checkOutput("refill2_count", DW'(issued.size()), DW'(13));

    // Prefetch disabled: entries still hit, misses still fetch, nothing is issued while idle.
    pf_en = 1'b0;
    applyStimulus(28'h0000106, dataOut, latOut, mrOut);
    checkOutput("pfoff_hit_data", dataOut, lineData(28'h0000106));
    checkOutput("pfoff_hit_lat", DW'(latOut), DW'(0));
    applyStimulus(28'h0000200, dataOut, latOut, mrOut);
    checkOutput("pfoff_miss_data", dataOut, lineData(28'h0000200));
    idle(30);
    checkOutput("pfoff_issue_count", DW'(issued.size()), DW'(14));
    checkOutput("pfoff_mem_read", DW'(mem_read), DW'(0));

    // Miss at the top of the address space; prefetch wraps through zero.
    pf_en = 1'b1;
    applyStimulus(28'hFFFFFFF, dataOut, latOut, mrOut);
    checkOutput("wrap_miss_data", dataOut, lineData(28'hFFFFFFF));
    idle(40);
    checkIssued("wrap_demand", 14, 28'hFFFFFFF);
    checkIssued("wrap_pf_0", 15, 28'h0000000);
    checkIssued("wrap_pf_1", 16, 28'h0000001);
    applyStimulus(28'h0000000, dataOut, latOut, mrOut);
    checkOutput("wrap_hit_data", dataOut, lineData(28'h0000000));
    checkOutput("wrap_hit_lat", DW'(latOut), DW'(0));
    checkOutput("wrap_hit_cnt", DW'(hit_cnt), DW'(5));
    checkOutput("wrap_miss_cnt", DW'(miss_cnt), DW'(4));

    // Four misses so far; thirteen more push the 4-bit miss counter past all-ones.
    pf_en = 1'b0;
    idle(2);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(28'h0000300 + AW'(i * 16), dataOut, latOut, mrOut);
    end
    checkOutput("sat_data", dataOut, lineData(28'h00003C0));
    checkOutput("miss_saturated", DW'(miss_cnt), DW'(4'hF));
    checkOutput("hit_cnt_held", DW'(hit_cnt), DW'(5));
    idle(1);

    // Reset while a demand read is outstanding.
    pf_en = 1'b1;
    cache_mem_addr = 28'h0000400;
    cache_mem_read = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("demand_inflight", DW'(mem_read), DW'(1));
    checkOutput("demand_addr", DW'(mem_addr), DW'(28'h0000400));
    @(negedge clk);
    rst = 1'b1;
    cache_mem_read = 1'b0;
    @(negedge clk);
    checkOutput("midrst_mem_read", DW'(mem_read), DW'(0));
    checkOutput("midrst_mem_addr", DW'(mem_addr), DW'(0));
    checkOutput("midrst_ready", DW'(cache_mem_ready), DW'(0));
    checkOutput("midrst_rdata", cache_mem_rdata, '0);
    checkOutput("midrst_miss_cnt", DW'(miss_cnt), DW'(0));
    checkOutput("midrst_hit_cnt", DW'(hit_cnt), DW'(0));
    rst = 1'b0;
    sizeMark = issued.size();
    idle(10);
    checkOutput("midrst_no_pf", DW'(issued.size()), DW'(sizeMark));
    applyStimulus(28'h0000500, dataOut, latOut, mrOut);
    checkOutput("post_rst_data", dataOut, lineData(28'h0000500));
    checkOutput("post_rst_lat", DW'(latOut), DW'(7));
    checkOutput("post_rst_miss_cnt", DW'(miss_cnt), DW'(1));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_prefetch_buffer.md
# stream_prefetch_buffer

Parametrised sequential-stream prefetcher between the L1 cache miss port and slow main memory. It is the next generation of the single-line next-line prefetcher. It keeps a ring of up to `DEPTH` consecutive prefetched lines, serves head hits combinationally, and refills the tail in the background whenever the cache is quiet. It adds a run-time enable and saturating hit/miss counters for performance tuning.

## Interface
- `ADDR_W`, 28, line-address width.
- `DATA_W`, 128, line width in bits.
- `DEPTH`, 4, ring entries; power of two, ≥2.
- `CNT_W`, 16, statistics counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cache_mem_read` in 1: cache miss request, held until `cache_mem_ready`.
- `cache_mem_addr` in ADDR_W: requested line address.
- `cache_mem_rdata` out DATA_W: returned line; 0 when not ready.
- `cache_mem_ready` out 1: one-cycle completion pulse.
- `mem_read` out 1: memory read request, registered.
- `mem_addr` out ADDR_W: memory line address, registered.
- `mem_ready` in 1: memory completion, one cycle.
- `mem_rdata` in DATA_W: memory data, valid with `mem_ready`.
- `pf_en` in 1: prefetch enable.
- `hit_cnt` out CNT_W: buffer hits, saturating.
- `miss_cnt` out CNT_W: buffer misses, saturating.

## Operation
- Ring state:
  - `head_addr`: address of the oldest entry.
  - `count`: 0..DEPTH.
  - `rd_ptr`, `wr_ptr`: log2(DEPTH)-bit pointers that wrap naturally.
  - `pf_active`: set on the first miss.
- Entry i holds line `head_addr+i`. The next prefetch address is `head_addr+count`, mod 2^ADDR_W.
- All address arithmetic wraps mod 2^ADDR_W. The line after all-ones is 0.
- States:
  - S_IDLE
  - S_DEMAND
  - S_READY
  - S_PREFETCH
- S_IDLE, request present, `count!=0` and `cache_mem_addr==head_addr` (hit):
  - `cache_mem_ready=1` and `cache_mem_rdata=ring[rd_ptr]` in the same cycle.
  - Pop: `rd_ptr++`, `head_addr++`, `count--`.
  - `hit_cnt++`. Stay in S_IDLE.
- S_IDLE, request present, otherwise (miss, including a match on a non-head entry):
  - Flush: `count=0`, `rd_ptr=wr_ptr`, `head_addr=cache_mem_addr+1`.
  - Set `pf_active=1`, `miss_cnt++`.
  - `mem_addr<=cache_mem_addr`, `mem_read<=1`, go to S_DEMAND.
- S_IDLE, no request, `pf_en && pf_active && count<DEPTH`:
  - `mem_addr<=head_addr+count`, `mem_read<=1`, go to S_PREFETCH.
- S_DEMAND: on `mem_ready`, capture data, `mem_read<=0`, go to S_READY.
- S_READY: `cache_mem_ready=1` with the captured data for one cycle, then S_IDLE.
- S_PREFETCH: on `mem_ready`, write `ring[wr_ptr]`, `wr_ptr++`, `count++`, `mem_read<=0`, go to S_IDLE.
- A demand request arriving during S_PREFETCH waits; memory reads cannot be aborted. After the fill, the request is evaluated in S_IDLE and may hit the line just fetched.
- `pf_en` low:
  - No new prefetches are issued.
  - An in-flight prefetch completes and is stored.
  - Existing entries remain hittable.
  - Misses still flush the ring.
- Counters stop at all-ones.

## Timing
- Reset values:
  - `mem_read=0`, `mem_addr=0`, `cache_mem_ready=0`, `cache_mem_rdata=0`.
  - `hit_cnt=0`, `miss_cnt=0`.
  - `count=0`, pointers 0, `head_addr=0`, `pf_active=0`, state S_IDLE.
- Hit latency: 0 cycles (combinational in the request cycle).
- Miss latency: request cycle, then `mem_read` high from the next cycle until `mem_ready`. `cache_mem_ready` follows 1 cycle after `mem_ready`.
- `mem_read` and `mem_addr` stay stable while a read is outstanding.
- Minimum one S_IDLE cycle between any two memory reads.
- Hit and prefetch issue never coincide; a demand request has priority.
- Reset mid-transfer: all state clears next edge. Memory is assumed to drop any outstanding `mem_ready` on reset.
- Full ring (`count==DEPTH`): no issue.
- Empty ring: every request misses.

## Structure
- Package `prefetch_pkg` holds:
  - the state enum (S_IDLE, S_DEMAND, S_READY, S_PREFETCH);
  - default parameter constants.
- Sub-module `prefetch_ring`:
  - DEPTH×DATA_W storage, pointers and `count`;
  - push, pop and flush ports;
  - head read data.
- Top-level holds the FSM, address tracking and counters.

## Test plan
- Cold miss at 0x0000100, memory latency 5 → `cache_mem_ready` 1 cycle after `mem_ready`. Then prefetches 0x0000101..0x0000104 issue and the ring fills to `count`=4 (DEPTH=4).
- Sequential reads 0x101, 0x102 after the fill → same-cycle ready with the correct data. `hit_cnt`=2. Prefetch 0x105, then 0x106, issued to refill.
- Read 0x103 while the head is 0x101 → miss and flush, demand fetch 0x103, `head_addr`=0x104, `miss_cnt` increments.
- Miss at 0xFFFFFFF → prefetch addresses wrap to 0x0000000 and 0x0000001, and a read of 0x0000000 hits.
- Demand 0x105 arrives during the in-flight prefetch of 0x105 → waits, then hits after the fill with no extra memory read. Separately, `pf_en`=0 → no `mem_read` while idle.
- Force `miss_cnt` to all-ones (CNT_W=4, 16 misses) → it holds at 0xF. Reset asserted during S_DEMAND → outputs 0 next cycle, state S_IDLE.
